// File: rtl/ddr3_mcb_ref_seq_pkg.sv
// Shared types and constants for the DDR3 MCB refresh sequencer: timing defaults,
// DDR3 {ras_n,cas_n,we_n} encodings, sequencer states and the registered command payload.
package ddr3_mcb_ref_seq_pkg;

   localparam int CtRP_DEF  = 6;
   localparam int CtRFC_DEF = 44;
   localparam int TW_DEF    = 8;
   localparam int NBANK     = 8;

   typedef logic [2:0] rcw_t;

   localparam rcw_t RCW_NOP  = 3'b111;
   localparam rcw_t RCW_PREA = 3'b010;
   localparam rcw_t RCW_REF  = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_PREA,
      S_TRP,
      S_REF,
      S_TRFC,
      S_DONE,
      S_HOLD
   } seq_state_e;

   typedef struct packed {
      logic vld;
      rcw_t rcw;
      logic a10;
   } cmd_t;

   // Valid and A10 follow from the encoding: only PRECHARGE ALL drives A10.
   function automatic cmd_t mk_cmd(input rcw_t rcw);
      cmd_t c;
      c.vld = (rcw != RCW_NOP);
      c.rcw = rcw;
      c.a10 = (rcw == RCW_PREA);
      return c;
   endfunction

endpackage

// File: rtl/ddr3_mcb_ref_seq_if.sv
// Refresh sequencer bus: request side from ref_ctl/bank tracker, command side to the DDR3 mux.
// DDR3_MCB_REF_STATS_EN adds the ref_done_cnt/ref_wait_max statistics outputs.
interface ddr3_mcb_ref_seq_if;
   import ddr3_mcb_ref_seq_pkg::*;

   logic             ref_req;
   logic             ref_alert;
   logic [NBANK-1:0] bank_open;
   logic             bus_idle;
   logic             ref_busy;
   logic             cmd_valid;
   logic             cmd_ready;
   rcw_t             cmd_rcw;
   logic             cmd_a10;
   logic             c_ref;
`ifdef DDR3_MCB_REF_STATS_EN
   logic [15:0]      ref_done_cnt;
   logic [15:0]      ref_wait_max;
`endif

   modport slave (
      input  ref_req, ref_alert, bank_open, bus_idle, cmd_ready,
      output ref_busy, cmd_valid, cmd_rcw, cmd_a10, c_ref
`ifdef DDR3_MCB_REF_STATS_EN
      , output ref_done_cnt, ref_wait_max
`endif
   );

   modport master (
      output ref_req, ref_alert, bank_open, bus_idle, cmd_ready,
      input  ref_busy, cmd_valid, cmd_rcw, cmd_a10, c_ref
`ifdef DDR3_MCB_REF_STATS_EN
      , input ref_done_cnt, ref_wait_max
`endif
   );

endinterface

// File: rtl/ddr3_mcb_dly_cnt.sv
// Loadable TW-bit down-counter with zero flag; load wins over decrement, saturates at zero.
// Zero flag is combinational from the count register; no backpressure.
module ddr3_mcb_dly_cnt #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [TW-1:0] i_val,
   input  logic          i_dec,
   output logic          o_zero
);

   logic [TW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - TW'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ddr3_mcb_ref_seq.sv
// Refresh sequencer: fence arbiter, PRECHARGE ALL if any bank open, REFRESH, wait tRFC, pulse c_ref.
// All outputs registered; commands held stable until cmd_ready. DDR3_MCB_REF_STATS_EN adds statistics.
module ddr3_mcb_ref_seq
   import ddr3_mcb_ref_seq_pkg::*;
#(
   parameter int CtRP  = CtRP_DEF,
   parameter int CtRFC = CtRFC_DEF,
   parameter int TW    = TW_DEF
) (
   input  logic                  ddr3_mcb_clk,
   input  logic                  ddr3_mcb_rst_n,
   input  logic                  i_ready,
   ddr3_mcb_ref_seq_if.slave     bus
);

   seq_state_e    r_state;
   cmd_t          r_cmd;
   logic          r_busy;
   logic          r_cref;

   logic          w_cnt_load;
   logic          w_cnt_dec;
   logic          w_cnt_zero;
   logic [TW-1:0] w_cnt_val;
   logic          w_drain_exit;
   logic          w_done;

   assign w_drain_exit = (r_state == S_DRAIN) && i_ready && bus.ref_alert && bus.bus_idle;
   assign w_done       = (r_state == S_TRFC) && i_ready && w_cnt_zero;

   // One shared timer serves tRP, tRFC and the post-refresh hold window.
   always_comb begin
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      w_cnt_dec  = 1'b0;
      if (!i_ready) begin
         w_cnt_load = 1'b1;
      end else begin
         case (r_state)
            S_PREA: if (bus.cmd_ready) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = TW'(CtRP - 1);
            end
            S_REF: if (bus.cmd_ready) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = TW'(CtRFC - 1);
            end
            S_DONE: begin
               w_cnt_load = 1'b1;
               w_cnt_val  = TW'(1);
            end
            S_TRP, S_TRFC, S_HOLD: w_cnt_dec = 1'b1;
            default: ;
         endcase
      end
   end

   ddr3_mcb_dly_cnt #(.TW(TW)) u_dly_cnt (
      .clk    (ddr3_mcb_clk),
      .rst_n  (ddr3_mcb_rst_n),
      .i_load (w_cnt_load),
      .i_val  (w_cnt_val),
      .i_dec  (w_cnt_dec),
      .o_zero (w_cnt_zero)
   );

   always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
      if (!ddr3_mcb_rst_n) begin
         r_state <= S_IDLE;
         r_cmd   <= mk_cmd(RCW_NOP);
         r_busy  <= 1'b0;
         r_cref  <= 1'b0;
      end else if (!i_ready) begin
         // Losing init withdraws any unaccepted command and suppresses c_ref.
         r_state <= S_IDLE;
         r_cmd   <= mk_cmd(RCW_NOP);
         r_busy  <= 1'b0;
         r_cref  <= 1'b0;
      end else begin
         r_cref <= 1'b0;
         case (r_state)
            S_IDLE: if (bus.ref_req) begin
               r_state <= S_DRAIN;
               r_busy  <= 1'b1;
            end
            S_DRAIN: begin
               if (!bus.ref_alert) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_drain_exit) begin
                  if (|bus.bank_open) begin
                     r_state <= S_PREA;
                     r_cmd   <= mk_cmd(RCW_PREA);
                  end else begin
                     r_state <= S_REF;
                     r_cmd   <= mk_cmd(RCW_REF);
                  end
               end
            end
            S_PREA: if (bus.cmd_ready) begin
               r_state <= S_TRP;
               r_cmd   <= mk_cmd(RCW_NOP);
            end
            S_TRP: if (w_cnt_zero) begin
               r_state <= S_REF;
               r_cmd   <= mk_cmd(RCW_REF);
            end
            S_REF: if (bus.cmd_ready) begin
               r_state <= S_TRFC;
               r_cmd   <= mk_cmd(RCW_NOP);
            end
            S_TRFC: if (w_done) begin
               r_state <= S_DONE;
               r_cref  <= 1'b1;
               r_busy  <= 1'b0;
            end
            S_DONE: r_state <= S_HOLD;
            // ref_ctl lags c_ref by two cycles, so a stale ref_req is ignored here.
            S_HOLD: if (w_cnt_zero) begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ref_busy  = r_busy;
   assign bus.cmd_valid = r_cmd.vld;
   assign bus.cmd_rcw   = r_cmd.rcw;
   assign bus.cmd_a10   = r_cmd.a10;
   assign bus.c_ref     = r_cref;

`ifdef DDR3_MCB_REF_STATS_EN
   logic [15:0] r_done_cnt;
   logic [15:0] r_wait;
   logic [15:0] r_wait_max;

   always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
      if (!ddr3_mcb_rst_n) begin
         r_done_cnt <= '0;
         r_wait     <= '0;
         r_wait_max <= '0;
      end else begin
         if (w_done) begin
            r_done_cnt <= r_done_cnt + 16'd1;
         end
         if ((r_state == S_IDLE) && i_ready && bus.ref_req) begin
            r_wait <= 16'd1;
         end else if ((r_state == S_DRAIN) && (r_wait != 16'hFFFF)) begin
            r_wait <= r_wait + 16'd1;
         end
         if (w_drain_exit && (r_wait > r_wait_max)) begin
            r_wait_max <= r_wait;
         end
      end
   end

   assign bus.ref_done_cnt = r_done_cnt;
   assign bus.ref_wait_max = r_wait_max;
`endif

endmodule
